// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-word valid/ready holding register.
// Optional: define PARITY_CHECK_EN to expect a trailing even-parity bit per word.
module shift_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
`ifdef PARITY_CHECK_EN
    localparam int NBITS = DATA_WIDTH + 1,
`else
    localparam int NBITS = DATA_WIDTH,
`endif
    localparam int CW = $clog2(NBITS + 1)
) (
    input  logic                  clk,
    input  logic                  cl,
    input  logic                  bit_valid,
    input  logic                  input_bit,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic [CW-1:0]         bit_count
`ifdef PARITY_CHECK_EN
    ,
    output logic                  parity_err
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    hold_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] stage_q, stage_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovr_q, ovr_d;

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] word;
    logic [CW-1:0]         base_cnt;
    logic [CW-1:0]         cnt_inc;
    logic                  complete;
    logic                  consume;
    logic                  load;

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;
`endif

    // Next-state: shift stage, bit counter and holding-register handshake.
    always_comb begin
        base     = frame_start ? '0 : stage_q;
        base_cnt = frame_start ? '0 : cnt_q;
        cnt_inc  = base_cnt + CW'(1);

        if (MSB_FIRST) begin
            word = {base[DATA_WIDTH-2:0], input_bit};
        end else begin
            word = {input_bit, base[DATA_WIDTH-1:1]};
        end
`ifdef PARITY_CHECK_EN
        // The trailing parity bit never enters the data stage.
        if (base_cnt == CW'(DATA_WIDTH)) begin
            word = base;
        end
`endif

        complete = bit_valid && (cnt_inc == CW'(NBITS));
        consume  = (state_q == FULL) && dout_ready;
        load     = complete && ((state_q == EMPTY) || consume);

        stage_d = stage_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovr_d   = ovr_q;
        state_d = state_q;
`ifdef PARITY_CHECK_EN
        perr_d  = perr_q;
`endif

        if (bit_valid) begin
            stage_d = complete ? '0 : word;
            cnt_d   = complete ? '0 : cnt_inc;
        end

        if (load) begin
            dout_d  = word;
            state_d = FULL;
`ifdef PARITY_CHECK_EN
            perr_d  = (^base) ^ input_bit;
`endif
        end else if (complete) begin
            ovr_d = 1'b1;
        end else if (consume) begin
            state_d = EMPTY;
        end
    end

    // State register; clear discards any partial word and the held word.
    always_ff @(posedge clk) begin
        if (cl) begin
            state_q <= EMPTY;
            stage_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == FULL);
    assign overrun    = ovr_q;
    assign bit_count  = cnt_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: an LSB-first instance with a
// scoreboard on its output handshake, and an MSB-first instance.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       cl;
    logic       bv0, ib0, fs0, rdy0;
    logic [7:0] dout0;
    logic       dv0, ov0;
    logic [3:0] cnt0;
    logic       bv1, ib1, fs1, rdy1;
    logic [7:0] dout1;
    logic       dv1, ov1;
    logic [3:0] cnt1;
`ifdef PARITY_CHECK_EN
    logic       pe0, pe1;
`endif

    int vectors = 0;
    int errs    = 0;
    logic [7:0] sbq[$];

    shift_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .cl(cl), .bit_valid(bv0), .input_bit(ib0),
        .frame_start(fs0), .dout(dout0), .dout_valid(dv0),
        .dout_ready(rdy0), .overrun(ov0), .bit_count(cnt0)
`ifdef PARITY_CHECK_EN
        , .parity_err(pe0)
`endif
    );

    shift_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .cl(cl), .bit_valid(bv1), .input_bit(ib1),
        .frame_start(fs1), .dout(dout1), .dout_valid(dv1),
        .dout_ready(rdy1), .overrun(ov1), .bit_count(cnt1)
`ifdef PARITY_CHECK_EN
        , .parity_err(pe1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every word handed over on u0 must match the queue head.
    always @(negedge clk) begin
        if (!cl && dv0 && rdy0) begin
            chk("sb_pending", 32'(sbq.size() != 0), 32'(1));
            if (sbq.size() != 0) chk("sb_dout", 32'(dout0), 32'(sbq.pop_front()));
        end
    end

    task automatic send0(input logic [7:0] w, input int n, input bit fs,
                         input bit rdy_last, input bit push);
        for (int i = 0; i < n; i++) begin
            bv0 = 1'b1;
            ib0 = w[i];
            fs0 = fs && (i == 0);
            if (rdy_last && i == n - 1) rdy0 = 1'b1;
            if (push && i == n - 1) sbq.push_back(w);
            tick();
        end
        fs0 = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        cl = 1'b1;
        bv0 = 0; ib0 = 0; fs0 = 0; rdy0 = 0;
        bv1 = 0; ib1 = 0; fs1 = 0; rdy1 = 1;

        // Reset and idle
        tick();
        tick();
        cl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_dout", 32'(dout0), 32'(0));
            chk("idle_dv", 32'(dv0), 32'(0));
            chk("idle_ovr", 32'(ov0), 32'(0));
            chk("idle_cnt", 32'(cnt0), 32'(0));
            chk("idle_dv1", 32'(dv1), 32'(0));
        end

        // LSB-first 0xA5, ready high
        rdy0 = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bv0 = 1'b1;
            ib0 = w[i];
            if (i == 7) sbq.push_back(w);
            tick();
            chk("lsb_cnt", 32'(cnt0), (i == 7) ? 32'(0) : 32'(i + 1));
            chk("lsb_dv", 32'(dv0), (i == 7) ? 32'(1) : 32'(0));
        end
        chk("lsb_dout", 32'(dout0), 32'(8'hA5));
        bv0 = 1'b0;
        tick();
        chk("lsb_dv_pulse", 32'(dv0), 32'(0));

        // MSB-first 0x3C with idle gaps between bits
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            bv1 = 1'b1;
            ib1 = w[7 - i];
            tick();
            chk("msb_cnt", 32'(cnt1), (i == 7) ? 32'(0) : 32'(i + 1));
            chk("msb_dv", 32'(dv1), (i == 7) ? 32'(1) : 32'(0));
            if (i == 7) chk("msb_dout", 32'(dout1), 32'(8'h3C));
            bv1 = 1'b0;
            ib1 = 1'($urandom_range(0, 1));
            fs1 = 1'($urandom_range(0, 1));
            tick();
            chk("msb_gap_cnt", 32'(cnt1), (i == 7) ? 32'(0) : 32'(i + 1));
            chk("msb_gap_dv", 32'(dv1), 32'(0));
            fs1 = 1'b0;
        end

        // Stall then overrun
        rdy0 = 1'b0;
        send0(8'h11, 8, 1'b0, 1'b0, 1'b1);
        bv0 = 1'b0;
        chk("stall_dv", 32'(dv0), 32'(1));
        chk("stall_dout", 32'(dout0), 32'(8'h11));
        chk("stall_ovr0", 32'(ov0), 32'(0));
        send0(8'h22, 8, 1'b0, 1'b0, 1'b0);
        bv0 = 1'b0;
        chk("ovr_set", 32'(ov0), 32'(1));
        chk("ovr_dout", 32'(dout0), 32'(8'h11));
        chk("ovr_dv", 32'(dv0), 32'(1));
        rdy0 = 1'b1;
        tick();
        chk("drain_dv", 32'(dv0), 32'(0));
        chk("drain_ovr", 32'(ov0), 32'(1));
        chk("drain_dout", 32'(dout0), 32'(8'h11));
        tick();
        chk("ovr_sticky", 32'(ov0), 32'(1));

        // Clear, then consume and complete in the same cycle
        cl = 1'b1;
        tick();
        cl = 1'b0;
        chk("clr_ovr", 32'(ov0), 32'(0));
        chk("clr_dv", 32'(dv0), 32'(0));
        chk("clr_cnt", 32'(cnt0), 32'(0));
        rdy0 = 1'b0;
        send0(8'h01, 8, 1'b0, 1'b0, 1'b1);
        chk("b2b_dv1", 32'(dv0), 32'(1));
        send0(8'h02, 8, 1'b0, 1'b1, 1'b1);
        bv0 = 1'b0;
        chk("b2b_dv2", 32'(dv0), 32'(1));
        chk("b2b_dout", 32'(dout0), 32'(8'h02));
        chk("b2b_ovr", 32'(ov0), 32'(0));
        tick();
        chk("b2b_drain", 32'(dv0), 32'(0));

        // Resync: five stray bits then a framed 0xF0
        send0(8'h16, 5, 1'b0, 1'b0, 1'b0);
        chk("stray_cnt", 32'(cnt0), 32'(5));
        chk("stray_dv", 32'(dv0), 32'(0));
        send0(8'hF0, 8, 1'b1, 1'b0, 1'b1);
        bv0 = 1'b0;
        chk("resync_dv", 32'(dv0), 32'(1));
        chk("resync_dout", 32'(dout0), 32'(8'hF0));
        chk("resync_cnt", 32'(cnt0), 32'(0));
        tick();
        chk("resync_drain", 32'(dv0), 32'(0));
        chk("sb_empty", 32'(sbq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
